sync_fifo_cfg: RTL

Single-clock, parametrised FIFO for intra-domain buffering, e.g. between the register file / ALU path and the UART TX framer.
Generalises the dual-clock FIFO in the following ways:
- depth is decoupled from data width;
- two read modes: registered and first-word-fall-through (FWFT);
- occupancy count output;
- programmable almost-full / almost-empty thresholds;
- synchronous flush;
- sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/sync_fifo_mem.sv | 33 +++
 rtl/sync_fifo_cfg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the single-clock FIFO family.
//   FIFO_MODE_REG / FIFO_MODE_FWFT : values for the FWFT read-mode parameter
//   fifo_ptr_width()               : pointer width (address bits plus wrap bit)
package fifo_pkg;

   localparam int FIFO_MODE_REG  = 32'd0;
   localparam int FIFO_MODE_FWFT = 32'd1;

   // Address bits for the storage plus one wrap bit that tells full from empty.
   function automatic int fifo_ptr_width(input int depth);
      return $clog2(depth) + 32'd1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH storage.
//   clk      : write clock
//   wr_en    : store wr_data at wr_addr on the rising edge
//   wr_addr  : write address
//   wr_data  : write word
//   rd_addr  : read address
//   rd_data  : word at rd_addr (asynchronous read)
// The contents are never reset. The parent FIFO decides when a word is valid.
module sync_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Synchronous write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_fifo_cfg.sv
// sync_fifo_cfg: single-clock parametrised FIFO with registered or
// first-word-fall-through read, occupancy count, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
//   CLK          : clock, all state updates on the rising edge
//   RST          : asynchronous active-low reset
//   clr          : synchronous flush (priority over W_inc/R_inc)
//   W_inc/W_data : write request and word
//   R_inc        : read/pop request
//   R_data       : read word; R_valid marks it as valid
//   full/empty   : occupancy extremes
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
module sync_fifo_cfg
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       clr,
   input  logic                       W_inc,
   input  logic [DATA_WIDTH-1:0]      W_data,
   input  logic                       R_inc,
   output logic [DATA_WIDTH-1:0]      R_data,
   output logic                       R_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int PTR_WIDTH  = fifo_ptr_width(DEPTH);

   // Parameter sanity: stop elaboration on an impossible configuration.
   if ((DEPTH < 32'd2) || ((DEPTH & (DEPTH - 32'd1)) != 32'd0)) begin : g_bad_depth
      $fatal(1, "sync_fifo_cfg: DEPTH must be a power of two >= 2");
   end
   if ((AF_LEVEL < 32'd1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
      $fatal(1, "sync_fifo_cfg: AF_LEVEL must be in 1..DEPTH");
   end
   if ((AE_LEVEL < 32'd0) || (AE_LEVEL >= AF_LEVEL)) begin : g_bad_ae
      $fatal(1, "sync_fifo_cfg: AE_LEVEL must be >= 0 and < AF_LEVEL");
   end
   if ((FWFT != FIFO_MODE_REG) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
      $fatal(1, "sync_fifo_cfg: FWFT must be 0 or 1");
   end

   logic [PTR_WIDTH-1:0]  wr_ptr_r;
   logic [PTR_WIDTH-1:0]  rd_ptr_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  wr_en_s;
   logic                  rd_en_s;
   logic                  empty_s;
   logic                  full_s;
   logic [PTR_WIDTH-1:0]  count_s;
   logic [DATA_WIDTH-1:0] rd_word_s;

   // Status derived only from the registered pointers.
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                    (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
   assign count_s = wr_ptr_r - rd_ptr_r;

   assign empty        = empty_s;
   assign full         = full_s;
   assign count        = count_s;
   assign almost_full  = (count_s >= PTR_WIDTH'(AF_LEVEL));
   assign almost_empty = (count_s <= PTR_WIDTH'(AE_LEVEL));
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

   // Accept decisions use pre-edge flags, so a read does not make room for a
   // same-cycle write on a full FIFO (and vice versa when empty).
   always_comb begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
      if (clr) begin
         wr_en_s = 1'b0;
         rd_en_s = 1'b0;
      end else begin
         wr_en_s = W_inc & ~full_s;
         rd_en_s = R_inc & ~empty_s;
      end
   end

   // Read and write pointers, modulo 2*DEPTH through natural wrap.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (clr) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1'b1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1'b1);
         end
      end
   end

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (clr) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (W_inc && full_s) begin
            overflow_r <= 1'b1;
         end
         if (R_inc && empty_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (CLK),
      .wr_en   (wr_en_s),
      .wr_addr (wr_ptr_r[ADDR_WIDTH-1:0]),
      .wr_data (W_data),
      .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
      .rd_data (rd_word_s)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented as soon as it is stored; R_inc acknowledges it.
      assign R_data  = empty_s ? '0 : rd_word_s;
      assign R_valid = ~empty_s;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_data_r;
      logic                  r_valid_r;

      // Registered read stage: one-cycle latency, data holds between reads.
      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            r_data_r  <= '0;
            r_valid_r <= 1'b0;
         end else if (rd_en_s) begin
            r_data_r  <= rd_word_s;
            r_valid_r <= 1'b1;
         end else begin
            r_valid_r <= 1'b0;
         end
      end

      assign R_data  = r_data_r;
      assign R_valid = r_valid_r;
   end

endmodule
